// File: rtl/jtag_host.sv
// JTAG initiator: turns DR/IR scan and TAP-reset commands into TCK/TMS/TDI
// waveforms, collects TDO into a response word. TCK is clk divided by 2*CLK_DIV.
module jtag_host #(
  parameter int MAX_LEN = 64,
  parameter int CLK_DIV = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic [1:0]                   cmd_op,
  input  logic [$clog2(MAX_LEN+1)-1:0] cmd_len,
  input  logic [MAX_LEN-1:0]           cmd_data,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [MAX_LEN-1:0]           rsp_data,
  output logic                         tck,
  output logic                         tms,
  output logic                         tdi,
  input  logic                         tdo,
  output logic [2:0]                   fsm_state
);

  localparam int LW = $clog2(MAX_LEN + 1);
  localparam int IW = (LW < 3) ? 3 : LW;
  localparam int CW = (CLK_DIV < 2) ? 1 : $clog2(2 * CLK_DIV);
  localparam logic [CW-1:0] HALF = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] FULL = CW'(2 * CLK_DIV - 1);
  // TMS header patterns, bit 0 is sent first.
  localparam logic [5:0] INIT_SEQ = 6'b011111;
  localparam logic [5:0] DR_SEQ   = 6'b000001;
  localparam logic [5:0] IR_SEQ   = 6'b000011;
  localparam logic [5:0] POST_SEQ = 6'b000001;

  // Handshakes: a command transfers on a rising clk edge where cmd_valid &&
  // cmd_ready; a response transfers where rsp_valid && rsp_ready. The
  // producer holds valid and payload stable until the transfer edge.

  typedef enum logic [2:0] {INIT, IDLE, PRE, SHIFT, POST, RESP} state_t;

  state_t               state;
  logic [CW-1:0]        cnt;
  logic [IW-1:0]        bit_idx;
  logic [IW-1:0]        last_idx;
  logic [5:0]           seq;
  logic                 reset_cmd;
  logic [LW-1:0]        len;
  logic [MAX_LEN-1:0]   data;
  logic [MAX_LEN-1:0]   sel;
  logic [LW-1:0]        len_c;
  logic                 bit_last;

  assign len_c     = (cmd_len > LW'(MAX_LEN)) ? LW'(MAX_LEN) : cmd_len;
  assign bit_last  = (bit_idx == last_idx);
  assign fsm_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= INIT;
      cnt       <= '0;
      bit_idx   <= '0;
      last_idx  <= IW'(5);
      seq       <= INIT_SEQ;
      reset_cmd <= 1'b0;
      len       <= '0;
      data      <= '0;
      sel       <= '0;
      tck       <= 1'b0;
      tms       <= 1'b1;
      tdi       <= 1'b0;
      cmd_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            rsp_data  <= '0;
            data      <= cmd_data;
            len       <= len_c;
            bit_idx   <= '0;
            cnt       <= '0;
            if (cmd_op[1]) begin
              state     <= INIT;
              reset_cmd <= 1'b1;
              seq       <= INIT_SEQ;
              last_idx  <= IW'(5);
              tms       <= 1'b1;
            end else if (len_c == '0) begin
              state     <= RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= PRE;
              tms   <= 1'b1;
              if (cmd_op[0]) begin
                seq      <= IR_SEQ;
                last_idx <= IW'(3);
              end else begin
                seq      <= DR_SEQ;
                last_idx <= IW'(2);
              end
            end
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end

        // INIT, PRE, SHIFT and POST share one bit engine: tck low for the
        // first CLK_DIV cycles, high for the next CLK_DIV.
        default: begin
          cnt <= cnt + CW'(1);
          if (cnt == HALF) begin
            tck <= 1'b1;
            if (state == SHIFT && tdo) rsp_data <= rsp_data | sel;
          end
          if (cnt == FULL) begin
            tck <= 1'b0;
            cnt <= '0;
            if (!bit_last) begin
              bit_idx <= bit_idx + IW'(1);
              if (state == SHIFT) begin
                data <= data >> 1;
                sel  <= sel << 1;
                tdi  <= data[1];
                tms  <= (bit_idx + IW'(1) == last_idx);
              end else begin
                seq <= seq >> 1;
                tms <= seq[1];
              end
            end else begin
              bit_idx <= '0;
              case (state)
                INIT: begin
                  tms <= 1'b0;
                  if (reset_cmd) begin
                    state     <= RESP;
                    rsp_valid <= 1'b1;
                    reset_cmd <= 1'b0;
                  end else begin
                    state     <= IDLE;
                    cmd_ready <= 1'b1;
                  end
                end
                PRE: begin
                  state    <= SHIFT;
                  last_idx <= IW'(len) - IW'(1);
                  sel      <= {{(MAX_LEN-1){1'b0}}, 1'b1};
                  tdi      <= data[0];
                  tms      <= (len == LW'(1));
                end
                SHIFT: begin
                  state    <= POST;
                  last_idx <= IW'(1);
                  seq      <= POST_SEQ;
                  tms      <= 1'b1;
                  tdi      <= 1'b0;
                end
                default: begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  tms       <= 1'b0;
                end
              endcase
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jtag_host.sv
// Bench for jtag_host: drives commands against a behavioural IEEE 1149.1 TAP
// (IDCODE + BYPASS) and checks responses, TCK counts and TMS sequences.
module tb_jtag_host;

  localparam int MAX_LEN = 64;
  localparam int CLK_DIV = 4;
  localparam int LW      = $clog2(MAX_LEN + 1);
  localparam int LIMIT   = (MAX_LEN + 16) * 2 * CLK_DIV + 50;
  localparam logic [31:0] IDCODE = 32'h1BEEF001;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               cmd_valid = 1'b0;
  logic               cmd_ready;
  logic [1:0]         cmd_op = 2'd0;
  logic [LW-1:0]      cmd_len = '0;
  logic [MAX_LEN-1:0] cmd_data = '0;
  logic               rsp_valid;
  logic               rsp_ready = 1'b0;
  logic [MAX_LEN-1:0] rsp_data;
  logic               tck;
  logic               tms;
  logic               tdi;
  logic               tdo = 1'b0;
  logic [2:0]         fsm_state;

  int vectors = 0;
  int miscompares = 0;
  int tck_count = 0;
  int bad_width = 0;
  int high_run = 0;
  int low_run = 0;
  logic prev_tck = 1'b0;
  logic tms_q[$];
  logic [MAX_LEN-1:0] exp_q[$];
  logic [4:0] cur_ir = 5'd1;

  jtag_host #(.MAX_LEN(MAX_LEN), .CLK_DIV(CLK_DIV)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_len(cmd_len), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo), .fsm_state(fsm_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  // ---------------- TCK monitor ----------------
  always @(negedge clk) begin
    if (tck !== prev_tck) begin
      if (tck) begin
        tck_count++;
        tms_q.push_back(tms);
        if (low_run < CLK_DIV) bad_width++;
        high_run = 1;
      end else begin
        if (high_run != CLK_DIV) bad_width++;
        low_run = 1;
      end
    end else if (tck) high_run++;
    else low_run++;
    prev_tck = tck;
  end

  // ---------------- behavioural TAP ----------------
  localparam int TLR = 0, RTI = 1, SEL_DR = 2, CAP_DR = 3, SH_DR = 4, EX1_DR = 5,
                 PA_DR = 6, EX2_DR = 7, UPD_DR = 8, SEL_IR = 9, CAP_IR = 10,
                 SH_IR = 11, EX1_IR = 12, PA_IR = 13, EX2_IR = 14, UPD_IR = 15;
  int tap_st = TLR;
  logic [4:0]  tap_ir = 5'd1;
  logic [4:0]  ir_sh = 5'd0;
  logic [31:0] dr_sh = 32'd0;

  function automatic int tap_next(input int st, input logic m);
    case (st)
      TLR:    return m ? TLR : RTI;
      RTI:    return m ? SEL_DR : RTI;
      SEL_DR: return m ? SEL_IR : CAP_DR;
      CAP_DR: return m ? EX1_DR : SH_DR;
      SH_DR:  return m ? EX1_DR : SH_DR;
      EX1_DR: return m ? UPD_DR : PA_DR;
      PA_DR:  return m ? EX2_DR : PA_DR;
      EX2_DR: return m ? UPD_DR : SH_DR;
      UPD_DR: return m ? SEL_DR : RTI;
      SEL_IR: return m ? TLR : CAP_IR;
      CAP_IR: return m ? EX1_IR : SH_IR;
      SH_IR:  return m ? EX1_IR : SH_IR;
      EX1_IR: return m ? UPD_IR : PA_IR;
      PA_IR:  return m ? EX2_IR : PA_IR;
      EX2_IR: return m ? UPD_IR : SH_IR;
      default: return m ? SEL_DR : RTI;
    endcase
  endfunction

  always @(posedge tck) begin
    case (tap_st)
      TLR:    tap_ir = 5'd1;
      CAP_DR: dr_sh = (tap_ir == 5'd1) ? IDCODE : 32'd0;
      SH_DR:  if (tap_ir == 5'd1) dr_sh = {tdi, dr_sh[31:1]}; else dr_sh[0] = tdi;
      CAP_IR: ir_sh = 5'b00001;
      SH_IR:  ir_sh = {tdi, ir_sh[4:1]};
      UPD_IR: tap_ir = ir_sh;
      default: ;
    endcase
    tap_st = tap_next(tap_st, tms);
  end

  always @(negedge tck) begin
    if (tap_st == SH_DR) tdo = dr_sh[0];
    else if (tap_st == SH_IR) tdo = ir_sh[0];
    else tdo = 1'b0;
  end

  // ---------------- reference model ----------------
  // A scan returns the selected register's capture value followed by the
  // shifted-in data, truncated to the (clamped) scan length.
  function automatic logic [MAX_LEN-1:0] model_rsp(input logic [1:0] op, input int len,
                                                   input logic [MAX_LEN-1:0] data);
    int l;
    int cl;
    logic [MAX_LEN-1:0] cap;
    logic [MAX_LEN-1:0] m;
    if (op[1]) return '0;
    cl = (len > MAX_LEN) ? MAX_LEN : len;
    if (op == 2'd1) begin cap = 64'd1; l = 5; end
    else if (cur_ir == 5'd1) begin cap = 64'(IDCODE); l = 32; end
    else begin cap = '0; l = 1; end
    m = (cl >= MAX_LEN) ? '1 : ((64'd1 << cl) - 64'd1);
    return ((data << l) | cap) & m;
  endfunction

  function automatic void model_tms(input logic [1:0] op, input int len,
                                    output logic [127:0] bits, output int n);
    logic q[$];
    int cl;
    cl = (len > MAX_LEN) ? MAX_LEN : len;
    if (op[1]) q = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    else if (cl > 0) begin
      if (op == 2'd1) q = '{1'b1, 1'b1, 1'b0, 1'b0};
      else q = '{1'b1, 1'b0, 1'b0};
      for (int i = 0; i < cl; i++) q.push_back(i == cl - 1);
      q.push_back(1'b1);
      q.push_back(1'b0);
    end
    bits = '0;
    n = q.size();
    for (int i = 0; i < n && i < 128; i++) bits[i] = q[i];
  endfunction

  function automatic logic [127:0] pack_tms();
    logic [127:0] b;
    b = '0;
    for (int i = 0; i < tms_q.size() && i < 128; i++) b[i] = tms_q[i];
    return b;
  endfunction

  // ---------------- driver ----------------
  task automatic do_scan(input logic [1:0] op, input int len, input logic [MAX_LEN-1:0] data,
                         output logic [MAX_LEN-1:0] rsp, output int tcks, output int lat,
                         output logic [127:0] tbits, output int ntms);
    int n;
    rsp = '0; tcks = -1; lat = -1; tbits = '0; ntms = -1;
    @(negedge clk);
    cmd_op = op; cmd_len = LW'(len); cmd_data = data; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < LIMIT) begin @(negedge clk); n++; end
    if (!cmd_ready) begin
      vectors++; miscompares++;
      $display("FAIL accept_timeout: cmd_ready=%b after %0d cycles, required 1", cmd_ready, n);
      cmd_valid = 1'b0;
      return;
    end
    tms_q.delete(); tck_count = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < LIMIT) begin @(negedge clk); lat++; end
    if (!rsp_valid) begin
      vectors++; miscompares++;
      $display("FAIL rsp_timeout: rsp_valid=%b after %0d cycles, required 1", rsp_valid, lat);
      return;
    end
    rsp = rsp_data; tcks = tck_count; tbits = pack_tms(); ntms = tms_q.size();
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    if (op[1]) cur_ir = 5'd1;
    else if (op == 2'd1 && len == 5) cur_ir = data[4:0];
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int n;
    logic [127:0] eb;
    int en;
    repeat (3) @(negedge clk);
    vectors++;
    if ({tck, tms, tdi, cmd_ready, rsp_valid} !== 5'b01000) begin
      miscompares++;
      $display("FAIL reset_outputs: tck,tms,tdi,cmd_ready,rsp_valid=%b required 01000",
               {tck, tms, tdi, cmd_ready, rsp_valid});
    end
    vectors++;
    if (rsp_data !== '0) begin
      miscompares++; $display("FAIL reset_rsp_data: got %h required 0", rsp_data);
    end
    rst_n = 1'b1;
    tms_q.delete(); tck_count = 0;
    n = 0;
    while (!cmd_ready && n < LIMIT) begin @(negedge clk); n++; end
    vectors++;
    if (n != 12 * CLK_DIV && n != 12 * CLK_DIV + 1) begin
      miscompares++; $display("FAIL init_ready_latency: got %0d cycles required %0d(+1)", n, 12 * CLK_DIV);
    end
    model_tms(2'd2, 0, eb, en);
    vectors++;
    if (tck_count != en || pack_tms() !== eb) begin
      miscompares++;
      $display("FAIL init_tms: tcks=%0d bits=%h required tcks=%0d bits=%h", tck_count, pack_tms(), en, eb);
    end
    cur_ir = 5'd1;
  endtask

  task automatic test_bypass();
    logic [MAX_LEN-1:0] r, d, e;
    int t, lat, n, en, len;
    logic [127:0] tb, eb;
    e = model_rsp(2'd1, 5, 64'h1F);
    do_scan(2'd1, 5, 64'h1F, r, t, lat, tb, n);
    vectors++;
    if (r !== e || t != 11) begin
      miscompares++; $display("FAIL ir_bypass: rsp=%h tcks=%0d required rsp=%h tcks=11", r, t, e);
    end
    e = model_rsp(2'd0, 8, 64'hA5);
    model_tms(2'd0, 8, eb, en);
    do_scan(2'd0, 8, 64'hA5, r, t, lat, tb, n);
    vectors++;
    if (r !== e || r !== 64'h4A) begin
      miscompares++; $display("FAIL dr_bypass_a5: rsp=%h required %h", r, e);
    end
    vectors++;
    if (t != 13 || tb !== eb || n != en) begin
      miscompares++; $display("FAIL dr_bypass_tms: tcks=%0d bits=%h required tcks=13 bits=%h", t, tb, eb);
    end
    for (int k = 0; k < 6; k++) begin
      len = $urandom_range(1, MAX_LEN);
      d = {$urandom, $urandom};
      exp_q.push_back(model_rsp(2'd0, len, d));
      do_scan(2'd0, len, d, r, t, lat, tb, n);
      e = exp_q.pop_front();
      vectors++;
      if (r !== e || t != len + 5) begin
        miscompares++;
        $display("FAIL dr_bypass_rand len=%0d: rsp=%h tcks=%0d required rsp=%h tcks=%0d", len, r, t, e, len + 5);
      end
    end
  endtask

  task automatic test_idcode();
    logic [MAX_LEN-1:0] r, d, e;
    int t, lat, n, en, len;
    logic [127:0] tb, eb;
    model_tms(2'd1, 5, eb, en);
    do_scan(2'd1, 5, 64'h01, r, t, lat, tb, n);
    vectors++;
    if (t != 11 || n != en || tb !== eb || tb !== 128'h303) begin
      miscompares++; $display("FAIL ir_idcode_tms: tcks=%0d bits=%h required tcks=11 bits=%h", t, tb, eb);
    end
    do_scan(2'd0, 32, 64'h0, r, t, lat, tb, n);
    vectors++;
    if (r !== 64'h1BEEF001 || t != 37) begin
      miscompares++; $display("FAIL dr_idcode: rsp=%h tcks=%0d required 1beef001 tcks=37", r, t);
    end
    for (int k = 0; k < 3; k++) begin
      len = $urandom_range(33, MAX_LEN);
      d = {$urandom, $urandom};
      exp_q.push_back(model_rsp(2'd0, len, d));
      do_scan(2'd0, len, d, r, t, lat, tb, n);
      e = exp_q.pop_front();
      vectors++;
      if (r !== e) begin
        miscompares++; $display("FAIL dr_idcode_rand len=%0d: rsp=%h required %h", len, r, e);
      end
    end
  endtask

  task automatic test_hold();
    logic [MAX_LEN-1:0] e1, e2, d2;
    int n, t;
    e1 = model_rsp(2'd0, 16, 64'h0000_0000_0000_C3C3);
    d2 = {$urandom, $urandom};
    e2 = model_rsp(2'd0, 40, d2);
    @(negedge clk);
    cmd_op = 2'd0; cmd_len = LW'(16); cmd_data = 64'hC3C3; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < LIMIT) begin @(negedge clk); n++; end
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < LIMIT) begin @(negedge clk); n++; end
    t = tck_count;
    for (int i = 0; i < 10; i++) begin
      if (i == 2) begin
        cmd_op = 2'd0; cmd_len = LW'(40); cmd_data = d2; cmd_valid = 1'b1;
      end
      vectors++;
      if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_data !== e1) begin
        miscompares++;
        $display("FAIL hold_stable cyc=%0d: rsp_valid=%b cmd_ready=%b rsp=%h required 1 0 %h",
                 i, rsp_valid, cmd_ready, rsp_data, e1);
      end
      @(negedge clk);
    end
    vectors++;
    if (tck_count != t) begin
      miscompares++; $display("FAIL hold_no_tck: tcks=%0d required %0d", tck_count, t);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    vectors++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      miscompares++; $display("FAIL hold_release: rsp_valid=%b cmd_ready=%b required 0 1", rsp_valid, cmd_ready);
    end
    tms_q.delete(); tck_count = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (!rsp_valid && n < LIMIT) begin @(negedge clk); n++; end
    vectors++;
    if (rsp_data !== e2 || tck_count != 45) begin
      miscompares++; $display("FAIL held_cmd: rsp=%h tcks=%0d required %h tcks=45", rsp_data, tck_count, e2);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_boundaries();
    logic [MAX_LEN-1:0] r, d, e;
    int t, lat, n;
    logic [127:0] tb;
    do_scan(2'd0, 0, 64'hFFFF, r, t, lat, tb, n);
    vectors++;
    if (t != 0 || lat != 0 || r !== '0) begin
      miscompares++; $display("FAIL len0: tcks=%0d lat=%0d rsp=%h required 0 0 0", t, lat, r);
    end
    d = {$urandom, $urandom};
    e = model_rsp(2'd0, MAX_LEN + 5, d);
    do_scan(2'd0, MAX_LEN + 5, d, r, t, lat, tb, n);
    vectors++;
    if (t != MAX_LEN + 5 || r !== e) begin
      miscompares++; $display("FAIL len_clamp: tcks=%0d rsp=%h required %0d %h", t, r, MAX_LEN + 5, e);
    end
  endtask

  task automatic test_tap_reset();
    logic [MAX_LEN-1:0] r;
    int t, lat, n, en;
    logic [127:0] tb, eb;
    model_tms(2'd2, 0, eb, en);
    for (int k = 2; k < 4; k++) begin
      do_scan(2'd1, 5, 64'h1F, r, t, lat, tb, n);
      do_scan(2'(k), 8, 64'hFF, r, t, lat, tb, n);
      vectors++;
      if (r !== '0 || t != 6 || tb !== eb) begin
        miscompares++; $display("FAIL tap_reset op=%0d: rsp=%h tcks=%0d bits=%h required 0 6 %h", k, r, t, tb, eb);
      end
      do_scan(2'd0, 32, 64'h0, r, t, lat, tb, n);
      vectors++;
      if (r !== 64'(IDCODE)) begin
        miscompares++; $display("FAIL tap_reset_idcode op=%0d: rsp=%h required %h", k, r, IDCODE);
      end
    end
  endtask

  task automatic test_width();
    vectors++;
    if (bad_width != 0) begin
      miscompares++; $display("FAIL tck_width: %0d bad phases required 0", bad_width);
    end
  endtask

  task automatic test_reset_mid();
    logic [MAX_LEN-1:0] r;
    int n, t, lat, en;
    logic [127:0] tb, eb;
    @(negedge clk);
    cmd_op = 2'd0; cmd_len = LW'(16); cmd_data = 64'hBEEF; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < LIMIT) begin @(negedge clk); n++; end
    tck_count = 0;
    @(negedge clk);
    cmd_valid = 1'b0;
    n = 0;
    while (tck_count < 7 && n < LIMIT) begin @(negedge clk); n++; end
    rst_n = 1'b0;
    @(negedge clk);
    vectors++;
    if ({tck, tms, rsp_valid, cmd_ready} !== 4'b0100) begin
      miscompares++;
      $display("FAIL mid_reset: tck,tms,rsp_valid,cmd_ready=%b required 0100", {tck, tms, rsp_valid, cmd_ready});
    end
    rst_n = 1'b1;
    tms_q.delete(); tck_count = 0;
    n = 0;
    while (!cmd_ready && n < LIMIT) begin @(negedge clk); n++; end
    model_tms(2'd2, 0, eb, en);
    vectors++;
    if (tck_count != en || pack_tms() !== eb) begin
      miscompares++; $display("FAIL mid_reset_init: tcks=%0d bits=%h required %0d %h", tck_count, pack_tms(), en, eb);
    end
    cur_ir = 5'd1;
    do_scan(2'd0, 32, 64'h0, r, t, lat, tb, n);
    vectors++;
    if (r !== 64'(IDCODE)) begin
      miscompares++; $display("FAIL mid_reset_resync: rsp=%h required %h", r, IDCODE);
    end
  endtask

  initial begin
    test_reset();
    test_bypass();
    test_idcode();
    test_hold();
    test_boundaries();
    test_tap_reset();
    test_width();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
